// File: rtl/hwpe_ctrl_periph_pkg.sv
// Shared definitions for the HWPE peripheral register file:
// register byte offsets, job FSM state type and a word-index helper.
package hwpe_ctrl_periph_pkg;

    localparam logic [7:0] OFF_TRIGGER    = 8'h00;
    localparam logic [7:0] OFF_STATUS     = 8'h04;
    localparam logic [7:0] OFF_SOFT_CLEAR = 8'h08;
    localparam logic [7:0] OFF_ID         = 8'h0C;
    localparam logic [7:0] OFF_REG_BASE   = 8'h40;

    typedef enum logic {
        JOB_IDLE,
        JOB_RUNNING
    } job_state_t;

    function automatic logic [5:0] word_idx(input logic [7:0] off);
        return off[7:2];
    endfunction

endpackage

// File: rtl/hwpe_ctrl_job_fsm.sv
// Job control FSM: trigger starts a job, done_i ends it, clear aborts it.
// Ports: clk_i, rst_ni, trigger_i, clear_i, done_i -> start_o, busy_o, evt_o.
module hwpe_ctrl_job_fsm
    import hwpe_ctrl_periph_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic trigger_i,
    input  logic clear_i,
    input  logic done_i,
    output logic start_o,
    output logic busy_o,
    output logic evt_o
);

    job_state_t state_q;
    logic       start_q;
    logic       evt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= JOB_IDLE;
            start_q <= 1'b0;
            evt_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            evt_q   <= 1'b0;
            // Soft clear aborts any job silently, even one finishing now.
            if (clear_i) begin
                state_q <= JOB_IDLE;
            end else begin
                case (state_q)
                    JOB_IDLE: begin
                        if (trigger_i) begin
                            state_q <= JOB_RUNNING;
                            start_q <= 1'b1;
                        end
                    end
                    JOB_RUNNING: begin
                        if (done_i) begin
                            state_q <= JOB_IDLE;
                            evt_q   <= 1'b1;
                        end
                    end
                    default: state_q <= JOB_IDLE;
                endcase
            end
        end
    end

    assign start_o = start_q;
    assign busy_o  = (state_q == JOB_RUNNING);
    assign evt_o   = evt_q;

endmodule

// File: rtl/hwpe_ctrl_periph_regfile.sv
// HWPE peripheral slave: job register file, TRIGGER/STATUS/CLEAR/ID map,
// one-cycle response pipeline. Ports: periph_* bus, regs_o, start/clear/busy/evt, done_i.
module hwpe_ctrl_periph_regfile
    import hwpe_ctrl_periph_pkg::*;
#(
    parameter int unsigned ID_WIDTH = 8,
    parameter int unsigned N_REGS   = 16,
    parameter logic [31:0] HWPE_ID  = 32'h0000_0001
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     periph_req_i,
    output logic                     periph_gnt_o,
    input  logic [31:0]              periph_add_i,
    input  logic                     periph_wen_i,
    input  logic [3:0]               periph_be_i,
    input  logic [31:0]              periph_data_i,
    input  logic [ID_WIDTH-1:0]      periph_id_i,
    output logic [31:0]              periph_r_data_o,
    output logic                     periph_r_valid_o,
    output logic [ID_WIDTH-1:0]      periph_r_id_o,
    output logic [32*N_REGS-1:0]     regs_o,
    output logic                     start_o,
    output logic                     clear_o,
    output logic                     busy_o,
    input  logic                     done_i,
    output logic                     evt_o
);

    localparam int unsigned SEL_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;

    logic [N_REGS-1:0][31:0] regs_q;
    logic [5:0]              idx;
    logic [5:0]              reg_off;
    logic [SEL_W-1:0]        reg_sel;
    logic                    reg_hit;
    logic                    wr;
    logic                    trigger;
    logic                    clear;
    logic                    busy;
    logic [31:0]             rdata;
    logic                    clear_q;

    assign periph_gnt_o = periph_req_i;

    assign idx     = periph_add_i[7:2];
    assign reg_off = idx - word_idx(OFF_REG_BASE);
    assign reg_sel = reg_off[SEL_W-1:0];
    assign reg_hit = (idx >= word_idx(OFF_REG_BASE)) &&
                     (32'(reg_off) < N_REGS);

    assign wr      = periph_req_i && !periph_wen_i;
    assign trigger = wr && (idx == word_idx(OFF_TRIGGER));
    assign clear   = wr && (idx == word_idx(OFF_SOFT_CLEAR));

    hwpe_ctrl_job_fsm i_job_fsm (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .trigger_i (trigger),
        .clear_i   (clear),
        .done_i    (done_i),
        .start_o   (start_o),
        .busy_o    (busy),
        .evt_o     (evt_o)
    );

    assign busy_o = busy;

    // Read value reflects the state before this cycle's update.
    always_comb begin
        rdata = '0;
        case (1'b1)
            reg_hit:
                rdata = regs_q[reg_sel];
            (idx == word_idx(OFF_STATUS)):
                rdata = {31'b0, busy};
            (idx == word_idx(OFF_ID)):
                rdata = HWPE_ID;
            default:
                rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            regs_q <= '0;
        end else if (clear) begin
            regs_q <= '0;
        end else if (reg_hit && wr && !busy) begin
            for (int b = 0; b < 4; b++) begin
                if (periph_be_i[b]) begin
                    regs_q[reg_sel][8*b +: 8] <= periph_data_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            periph_r_valid_o <= 1'b0;
            periph_r_data_o  <= '0;
            periph_r_id_o    <= '0;
            clear_q          <= 1'b0;
        end else begin
            periph_r_valid_o <= periph_req_i;
            periph_r_data_o  <= (periph_req_i && periph_wen_i) ? rdata : '0;
            if (periph_req_i) begin
                periph_r_id_o <= periph_id_i;
            end
            clear_q <= clear;
        end
    end

    assign clear_o = clear_q;
    assign regs_o  = regs_q;

endmodule

// File: tb/tb_hwpe_ctrl_periph_regfile.sv
// Bench for hwpe_ctrl_periph_regfile: directed vector table, random traffic
// against a behavioural model, and reset/corner sequences.
module tb_hwpe_ctrl_periph_regfile;

    localparam int          IDW = 8;
    localparam int          N   = 16;
    localparam int          W   = 32 * N;
    localparam logic [31:0] HID = 32'h0000_0001;
    localparam logic        H   = 1'b1;
    localparam logic        L   = 1'b0;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           req = 1'b0;
    logic           gnt;
    logic [31:0]    add = '0;
    logic           wen = 1'b1;
    logic [3:0]     be = '0;
    logic [31:0]    wdata = '0;
    logic [IDW-1:0] id = '0;
    logic [31:0]    r_data;
    logic           r_valid;
    logic [IDW-1:0] r_id;
    logic [W-1:0]   regs;
    logic           start;
    logic           clear;
    logic           busy;
    logic           done = 1'b0;
    logic           evt;

    hwpe_ctrl_periph_regfile #(
        .ID_WIDTH (IDW),
        .N_REGS   (N),
        .HWPE_ID  (HID)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .periph_req_i     (req),
        .periph_gnt_o     (gnt),
        .periph_add_i     (add),
        .periph_wen_i     (wen),
        .periph_be_i      (be),
        .periph_data_i    (wdata),
        .periph_id_i      (id),
        .periph_r_data_o  (r_data),
        .periph_r_valid_o (r_valid),
        .periph_r_id_o    (r_id),
        .regs_o           (regs),
        .start_o          (start),
        .clear_o          (clear),
        .busy_o           (busy),
        .done_i           (done),
        .evt_o            (evt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] mregs [N];
    logic        mbusy;

    typedef struct packed {
        logic        req;
        logic        wen;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic [7:0]  id;
        logic        done;
        logic        e_valid;
        logic [31:0] e_data;
        logic        e_start;
        logic        e_busy;
        logic        e_evt;
        logic        e_clear;
    } vec_t;

    vec_t tbl [21];

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mread(input logic [31:0] a);
        int i;
        i = int'(a[7:2]);
        if (i == 1) return {31'b0, mbusy};
        if (i == 3) return HID;
        if (i >= 16 && i < 16 + N) return mregs[i-16];
        return 32'h0;
    endfunction

    task automatic mreset();
        mbusy = 1'b0;
        foreach (mregs[k]) mregs[k] = 32'h0;
    endtask

    task automatic cyc(input logic q, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d,
                       input logic [7:0] t, input logic dn);
        logic [31:0] e_data;
        logic        e_start;
        logic        e_clear;
        logic        e_evt;
        logic        wr_;
        int          i;
        logic [W-1:0] e_regs;
        @(negedge clk);
        req = q; wen = w; add = a; be = b; wdata = d; id = t; done = dn;
        i = int'(a[7:2]);
        wr_ = q & ~w;
        e_data  = (q & w) ? mread(a) : 32'h0;
        e_clear = wr_ && (i == 2);
        e_start = wr_ && (i == 0) && !mbusy;
        e_evt   = mbusy && dn && !e_clear;
        if (e_clear) begin
            mreset();
        end else begin
            if (wr_ && i >= 16 && i < 16 + N && !mbusy) begin
                for (int k = 0; k < 4; k++)
                    if (b[k]) mregs[i-16][8*k +: 8] = d[8*k +: 8];
            end
            if (mbusy && dn) mbusy = 1'b0;
            else if (e_start) mbusy = 1'b1;
        end
        for (int k = 0; k < N; k++) e_regs[32*k +: 32] = mregs[k];
        #1;
        chk("gnt", W'(gnt), W'(q));
        @(posedge clk);
        #1;
        chk("r_valid", W'(r_valid), W'(q));
        if (q) begin
            chk("r_id", W'(r_id), W'(t));
            chk("r_data", W'(r_data), W'(e_data));
        end
        chk("start", W'(start), W'(e_start));
        chk("clear", W'(clear), W'(e_clear));
        chk("evt", W'(evt), W'(e_evt));
        chk("busy", W'(busy), W'(mbusy));
        chk("regs", regs, e_regs);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ra;
        logic [5:0]  ix;
        int          s;

        tbl[0]  = '{H, H, 32'h0C, 4'h0, 32'h0, 8'd7, L,
                    H, 32'h1, L, L, L, L};
        tbl[1]  = '{H, L, 32'h48, 4'hF, 32'hAABBCCDD, 8'd1, L,
                    H, 32'h0, L, L, L, L};
        tbl[2]  = '{H, L, 32'h48, 4'h2, 32'h00001100, 8'd2, L,
                    H, 32'h0, L, L, L, L};
        tbl[3]  = '{H, H, 32'h48, 4'h0, 32'h0, 8'd3, L,
                    H, 32'hAABB11DD, L, L, L, L};
        tbl[4]  = '{H, L, 32'h00, 4'hF, 32'h0, 8'd4, L,
                    H, 32'h0, H, H, L, L};
        tbl[5]  = '{H, H, 32'h04, 4'h0, 32'h0, 8'd5, L,
                    H, 32'h1, L, H, L, L};
        tbl[6]  = '{H, L, 32'h40, 4'hF, 32'h12345678, 8'd6, L,
                    H, 32'h0, L, H, L, L};
        tbl[7]  = '{H, H, 32'h40, 4'h0, 32'h0, 8'd7, L,
                    H, 32'h0, L, H, L, L};
        tbl[8]  = '{L, H, 32'h00, 4'h0, 32'h0, 8'd8, H,
                    L, 32'h0, L, L, H, L};
        tbl[9]  = '{H, H, 32'h04, 4'h0, 32'h0, 8'd9, H,
                    H, 32'h0, L, L, L, L};
        tbl[10] = '{H, L, 32'h00, 4'hF, 32'h0, 8'd10, L,
                    H, 32'h0, H, H, L, L};
        tbl[11] = '{H, L, 32'h00, 4'hF, 32'h0, 8'd11, H,
                    H, 32'h0, L, L, H, L};
        tbl[12] = '{L, H, 32'h00, 4'h0, 32'h0, 8'd12, L,
                    L, 32'h0, L, L, L, L};
        tbl[13] = '{H, L, 32'h00, 4'hF, 32'h0, 8'd13, L,
                    H, 32'h0, H, H, L, L};
        tbl[14] = '{H, L, 32'h08, 4'hF, 32'h0, 8'd14, H,
                    H, 32'h0, L, L, L, H};
        tbl[15] = '{H, H, 32'h48, 4'h0, 32'h0, 8'd15, L,
                    H, 32'h0, L, L, L, L};
        tbl[16] = '{H, H, 32'h0C, 4'h0, 32'h0, 8'd3, L,
                    H, 32'h1, L, L, L, L};
        tbl[17] = '{H, H, 32'h0C, 4'h0, 32'h0, 8'd4, L,
                    H, 32'h1, L, L, L, L};
        tbl[18] = '{H, H, 32'h0C, 4'h0, 32'h0, 8'd5, L,
                    H, 32'h1, L, L, L, L};
        tbl[19] = '{H, H, 32'h20, 4'h0, 32'h0, 8'd20, L,
                    H, 32'h0, L, L, L, L};
        tbl[20] = '{L, H, 32'h00, 4'h0, 32'h0, 8'd21, L,
                    L, 32'h0, L, L, L, L};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out",
            W'({r_valid, r_data, r_id, start, clear, evt, busy}), W'(0));
        chk("reset_regs", regs, '0);
        chk("reset_gnt0", W'(gnt), W'(1'b0));
        req = 1'b1;
        #1;
        chk("reset_gnt1", W'(gnt), W'(1'b1));
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mreset();

        // Directed table
        foreach (tbl[v]) begin
            logic [36:0] act;
            logic [36:0] exp;
            cyc(tbl[v].req, tbl[v].wen, tbl[v].addr, tbl[v].be,
                tbl[v].data, tbl[v].id, tbl[v].done);
            act = {r_valid, r_valid ? r_data : 32'h0, start, busy, evt, clear};
            exp = {tbl[v].e_valid, tbl[v].e_data, tbl[v].e_start,
                   tbl[v].e_busy, tbl[v].e_evt, tbl[v].e_clear};
            chk($sformatf("vec%0d", v), W'(act), W'(exp));
        end

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            s = $urandom_range(0, 15);
            ix = 6'($urandom_range(0, 63));
            case (s)
                0, 1:   ix = 6'd0;
                2:      ix = 6'd1;
                3:      ix = ($urandom_range(0, 3) == 0) ? 6'd2 : 6'd1;
                4:      ix = 6'd3;
                5, 6:   ;
                default: ix = 6'(16 + $urandom_range(0, N - 1));
            endcase
            ra = $urandom();
            ra[7:2] = ix;
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                ra, 4'($urandom_range(0, 15)), $urandom(),
                8'($urandom_range(0, 255)),
                1'($urandom_range(0, 7) == 0));
        end

        // Reset in the middle of a job drops the pending response
        cyc(H, L, 32'h08, 4'hF, 32'h0, 8'd1, L);
        cyc(H, L, 32'h00, 4'hF, 32'h0, 8'd2, L);
        @(negedge clk);
        req = 1'b1; wen = 1'b1; add = 32'h04; id = 8'd9; done = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_valid", W'({r_valid, r_data}), W'({1'b1, 32'h1}));
        rst_n = 1'b0;
        #1;
        chk("mid_reset",
            W'({r_valid, r_data, start, evt, clear, busy}), W'(0));
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mreset();
        cyc(L, H, 32'h0, 4'h0, 32'h0, 8'd0, L);
        cyc(H, H, 32'h04, 4'h0, 32'h0, 8'd3, H);
        cyc(L, H, 32'h0, 4'h0, 32'h0, 8'd0, L);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
